interrupt_priority_resolver: RTL
================================

// Module: interrupt_priority_resolver
// PURPOSE
// - Clocked IRR/ISR/priority-resolver stage of the 8259 PIC. It sits directly upstream of Control_Unit.
// - Latches IR0..IR7 requests into the IRR and resolves priority against the mask and the ISR.
// - Drives INTERNAL_INT and IR_NUM to Control_Unit.
// - Updates the ISR on INTA_ edges and on EOI commands decoded by Control_Unit.
// PARAMETERS
// - NUM_IR       8  number of request lines; only 8 is supported, the parameter exists for the package.
// - SYNC_STAGES  2  synchronizer depth on IR and INTA_; legal range 1..3.
// PORTS
// - CLK              in   1  single clock; all logic is rising-edge.
// - RST              in   1  synchronous, active-high reset.
// - IR               in   8  asynchronous interrupt request lines; bit i = IRi.
// - LEVEL            in   1  1 = level-triggered, 0 = edge-triggered (ICW1 LTIM).
// - interrupt_mask   in   8  OCW1 mask; 1 = masked.
// - INTA_            in   1  active-low acknowledge from the CPU.
// - AEOI             in   1  auto-EOI enable (ICW4).
// - EOI_STB          in   1  one-cycle strobe that executes the OCW2 EOI command.
// - EOI_SPECIFIC     in   1  1 = specific EOI, using EOI_LEVEL.
// - EOI_LEVEL        in   3  IR level for a specific EOI.
// - RIRR             in   1  OCW3 read request: select IRR onto STATUS.
// - RISR             in   1  OCW3 read request: select ISR onto STATUS.
// - INTERNAL_INT     out  1  registered: an unmasked request beats the current ISR.
// - IR_NUM           out  3  registered: resolved or frozen vector level.
// - STATUS           out  8  RISR ? ISR : IRR; RIRR/RISR priority follows OCW3 (RISR wins).
// BEHAVIOUR
// - Reset values: IRR=0, ISR=0, INTERNAL_INT=0, IR_NUM=0, STATUS=0, state=IDLE, lowest-priority pointer=7 (IR0 highest).
// - Synchronizers: IR and INTA_ pass through SYNC_STAGES flops. Latency from an IR pin edge to INTERNAL_INT is SYNC_STAGES+2 cycles.
// - IRR update, edge mode: bit i sets on a synchronized 0->1 transition of IR[i].
// - IRR update, level mode: bit i follows synchronized IR[i].
// - IRR clear, both modes: bit i clears whenever synchronized IR[i]=0.
// - Priority order: with pointer p, IR(p+1) mod 8 is highest and IRp is lowest. Wrap-around is modulo 8.
// - Candidate: highest-priority bit of IRR & ~interrupt_mask.
// - INTERNAL_INT=1 only if a candidate exists and it is strictly higher priority than the highest set ISR bit, or the ISR is empty. IR_NUM tracks the candidate while in IDLE.
// - FSM, IDLE -> ACK1: on a synchronized falling edge of INTA_.
//   - Freeze IR_NUM.
//   - Set ISR[IR_NUM] and clear IRR[IR_NUM].
//   - Drop INTERNAL_INT on the next cycle.
// - Spurious acknowledge: if no candidate exists at the first INTA_ edge, IR_NUM=7 and the ISR is untouched.
// - FSM, ACK1 -> ACK2: on the second INTA_ falling edge. If AEOI=1, clear ISR[IR_NUM] on this edge.
// - FSM, ACK2 -> IDLE: when INTA_ returns high. IR_NUM unfreezes.
// - Non-specific EOI: clears the highest-priority set ISR bit. No-op if the ISR is empty.
// - Specific EOI: clears ISR[EOI_LEVEL].
// - Simultaneous events:
//   - EOI and an INTA_ edge in the same cycle: the EOI clear applies first, then the ISR set. Set wins on the same bit.
//   - A new IR edge and an INTA_ IRR-clear on the same bit in the same cycle: the clear wins.
// - RST asserted mid-acknowledge: FSM returns to IDLE and all state returns to reset values in the same cycle.
// - Further INTA_ edges in IDLE with no candidate follow the spurious rule above.
// CONFIGURATION
// - PRIO_ROTATE_EN defined:
//   - Adds input ROTATE (1 bit).
//   - An EOI with ROTATE=1, or an AEOI clear while ROTATE=1, loads pointer p with the cleared level, so that level becomes lowest priority.
// - PRIO_ROTATE_EN undefined:
//   - No ROTATE port.
//   - p is constant 7, giving fully nested priority with IR0 highest.
// STRUCTURE
// - Package pic_pkg:
//   - typedef ack_state_t {IDLE, ACK1, ACK2}.
//   - localparam IR_W=3 and NUM_IR=8.
//   - localparam SPURIOUS_IR=3'd7.
// - Sub-module rot_prio_encoder: combinational. Takes an 8-bit vector and p; returns valid plus the 3-bit highest-priority level. It is instantiated twice, once for the IRR candidate and once for the highest ISR bit.
// TESTING
// - Edge mode, mask=0, pulse IR3 then IR5:
//   - INTERNAL_INT=1 and IR_NUM=3.
//   - Two INTA_ pulses -> ISR=8'h08, IRR=8'h20.
//   - INTERNAL_INT stays 0 while ISR[3] is set.
// - Nesting: with ISR=8'h08, raise IR1 -> INTERNAL_INT=1 and IR_NUM=1. After the acknowledge, ISR=8'h0A.
// - Non-specific EOI with ISR=8'h0A -> ISR=8'h08. A specific EOI with EOI_LEVEL=3 then gives ISR=8'h00.
// - AEOI=1: acknowledge IR6 -> ISR[6] is set after the first INTA_ and cleared after the second. Final ISR=8'h00.
// - Mask=8'h04 with IR2 held high -> INTERNAL_INT=0 and STATUS (RIRR) shows 8'h04. Then mask=0 -> INTERNAL_INT=1 and IR_NUM=2.
// - Spurious: IR4 drops before the first INTA_ -> IR_NUM=7 and ISR=0.
// - PRIO_ROTATE_EN: EOI with ROTATE=1 on level 4 -> p=4. Then IR5 and IR0 pending together -> IR_NUM=5.
// - RST asserted in ACK1 -> next cycle IRR=ISR=0, INTERNAL_INT=0 and the FSM is in IDLE.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt priority resolver.
package pic_pkg;

  localparam int IR_W   = 3;
  localparam int NUM_IR = 8;

  localparam logic [IR_W-1:0] SPURIOUS_IR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } ack_state_t;

  // Position of a level in the rotated priority order: 0 = highest (ptr+1), 7 = lowest (ptr).
  function automatic logic [IR_W-1:0] prio_rank(input logic [IR_W-1:0] lvl,
                                                input logic [IR_W-1:0] ptr);
    return lvl - ptr - 3'd1;
  endfunction

endpackage

// File: rtl/rot_prio_encoder.sv
// Rotating priority encoder: level ptr+1 (mod 8) is highest, level ptr is lowest.
module rot_prio_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [IR_W-1:0]   ptr,
  output logic              valid,
  output logic [IR_W-1:0]   level
);

  always_comb begin
    logic [IR_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    level = '0;
    idx   = '0;
    // Walk from lowest to highest priority so the highest set bit is written last.
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = ptr + IR_W'(i) + IR_W'(1);
      if (vec[idx]) level = idx;
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/interrupt_priority_resolver.sv
// IRR/ISR/priority-resolver stage of an 8259 PIC, feeding Control_Unit.
// Optional feature: define PRIO_ROTATE_EN to add the ROTATE input and a rotating priority pointer.
module interrupt_priority_resolver #(
  parameter int NUM_IR      = pic_pkg::NUM_IR,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_IR-1:0]        IR,
  input  logic                     LEVEL,
  input  logic [NUM_IR-1:0]        interrupt_mask,
  input  logic                     INTA_,
  input  logic                     AEOI,
  input  logic                     EOI_STB,
  input  logic                     EOI_SPECIFIC,
  input  logic [pic_pkg::IR_W-1:0] EOI_LEVEL,
  input  logic                     RIRR,
  input  logic                     RISR,
`ifdef PRIO_ROTATE_EN
  input  logic                     ROTATE,
`endif
  output logic                     INTERNAL_INT,
  output logic [pic_pkg::IR_W-1:0] IR_NUM,
  output logic [NUM_IR-1:0]        STATUS
);
  import pic_pkg::*;

  logic [NUM_IR-1:0] ir_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] inta_pipe;
  logic [NUM_IR-1:0] ir_s, ir_prev, rise;
  logic              inta_s, inta_prev, inta_fall;

  logic [NUM_IR-1:0] irr, isr, irr_n, isr_n, req;
  ack_state_t        state;
  logic              spurious;
  logic [IR_W-1:0]   ptr;

  logic              cand_valid, isr_valid, beats;
  logic [IR_W-1:0]   cand_lvl, isr_lvl, eoi_lvl;
  logic              ack1, ack2, eoi_hit, aeoi_hit;

  // The synchronizer chain is a handful of flops, so it is reset along with everything else.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        ir_pipe[s]   <= '0;
        inta_pipe[s] <= 1'b1;
      end
      ir_prev   <= '0;
      inta_prev <= 1'b1;
    end else begin
      ir_pipe[0]   <= IR;
      inta_pipe[0] <= INTA_;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        ir_pipe[s]   <= ir_pipe[s-1];
        inta_pipe[s] <= inta_pipe[s-1];
      end
      ir_prev   <= ir_s;
      inta_prev <= inta_s;
    end
  end

  assign ir_s      = ir_pipe[SYNC_STAGES-1];
  assign inta_s    = inta_pipe[SYNC_STAGES-1];
  assign rise      = ir_s & ~ir_prev;
  assign inta_fall = inta_prev & ~inta_s;
  assign req       = irr & ~interrupt_mask;

  rot_prio_encoder u_cand_enc (.vec(req), .ptr(ptr), .valid(cand_valid), .level(cand_lvl));
  rot_prio_encoder u_isr_enc  (.vec(isr), .ptr(ptr), .valid(isr_valid),  .level(isr_lvl));

  assign beats    = cand_valid && (!isr_valid || (prio_rank(cand_lvl, ptr) < prio_rank(isr_lvl, ptr)));
  assign ack1     = (state == IDLE) && inta_fall;
  assign ack2     = (state == ACK1) && inta_fall;
  assign eoi_lvl  = EOI_SPECIFIC ? EOI_LEVEL : isr_lvl;
  assign eoi_hit  = EOI_STB && (EOI_SPECIFIC || isr_valid);
  assign aeoi_hit = ack2 && AEOI && !spurious;

  // EOI clears land before the acknowledge set, so a set on the same bit survives.
  always_comb begin
    irr_n = LEVEL ? ir_s : ((irr | rise) & ir_s);
    isr_n = isr;
    if (eoi_hit)  isr_n[eoi_lvl] = 1'b0;
    if (aeoi_hit) isr_n[IR_NUM]  = 1'b0;
    if (ack1 && cand_valid) begin
      isr_n[cand_lvl] = 1'b1;
      irr_n[cand_lvl] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      irr          <= '0;
      isr          <= '0;
      state        <= IDLE;
      spurious     <= 1'b0;
      INTERNAL_INT <= 1'b0;
      IR_NUM       <= '0;
    end else begin
      irr          <= irr_n;
      isr          <= isr_n;
      INTERNAL_INT <= (state == IDLE) && !inta_fall && beats;
      case (state)
        IDLE: begin
          if (inta_fall) begin
            state    <= ACK1;
            spurious <= !cand_valid;
            IR_NUM   <= cand_valid ? cand_lvl : SPURIOUS_IR;
          end else if (cand_valid) begin
            IR_NUM <= cand_lvl;
          end
        end
        ACK1:    if (inta_fall) state <= ACK2;
        ACK2:    if (inta_s)    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRIO_ROTATE_EN
  always_ff @(posedge CLK) begin
    if (RST)                     ptr <= 3'd7;
    else if (aeoi_hit && ROTATE) ptr <= IR_NUM;
    else if (eoi_hit && ROTATE)  ptr <= eoi_lvl;
  end
`else
  // Fully nested mode: IR0 highest, IR7 lowest.
  assign ptr = 3'd7;
`endif

  // RIRR only selects IRR, which is already the read-back whenever RISR is low.
  logic rirr_unused;
  assign rirr_unused = RIRR;
  assign STATUS      = RISR ? isr : irr;

endmodule
